// File: rtl/adc_frame_builder.sv
// Packs ADC sample words read from a non-show-ahead FIFO into byte-wide frames:
// a 4-byte header (sync pattern + sequence number) followed by WORDS_PER_FRAME words, MSB byte first.
module adc_frame_builder #(
    parameter int          ADC_BITS        = 12,
    parameter int          SAMPLES         = 4,
    parameter int          WORDS_PER_FRAME = 32,
    parameter logic [15:0] HDR_MAGIC       = 16'hA5C3
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         fifo_empty,
    input  logic [ADC_BITS*SAMPLES-1:0]  fifo_rd_data,
    output logic                         fifo_rd_en,
    output logic [7:0]                   byte_data,
    output logic                         byte_valid,
    input  logic                         byte_ready,
    output logic                         byte_first,
    output logic                         byte_last,
    output logic [15:0]                  frame_seq,
    output logic                         busy
);

    localparam int WORD_W = ADC_BITS * SAMPLES;
    localparam int BPW    = WORD_W / 8;
    localparam int BCW    = $clog2(BPW + 4);
    localparam int WCW    = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WAIT_RD = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    state_t              state_r;
    logic [BCW-1:0]      byte_cnt_r;
    logic [WCW-1:0]      word_cnt_r;
    logic [WORD_W-1:0]   shift_r;
    logic [15:0]         frame_seq_r;

    logic                accept_s;
    logic                last_byte_s;
    logic                last_word_s;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] seq);
        case (idx)
            2'd0:    hdr_byte = HDR_MAGIC[15:8];
            2'd1:    hdr_byte = HDR_MAGIC[7:0];
            2'd2:    hdr_byte = seq[15:8];
            2'd3:    hdr_byte = seq[7:0];
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    assign accept_s    = byte_valid & byte_ready;
    assign last_byte_s = (byte_cnt_r == BCW'(BPW - 1));
    assign last_word_s = (word_cnt_r == WCW'(WORDS_PER_FRAME - 1));
    assign frame_seq   = frame_seq_r;

    // Frame sequencer: the FIFO read strobe is decided one edge early so that it is a
    // register yet still costs only FETCH + WAIT_RD idle cycles between words.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= {BCW{1'b0}};
            word_cnt_r  <= {WCW{1'b0}};
            shift_r     <= {WORD_W{1'b0}};
            frame_seq_r <= 16'h0000;
            fifo_rd_en  <= 1'b0;
            byte_data   <= 8'h00;
            byte_valid  <= 1'b0;
            byte_first  <= 1'b0;
            byte_last   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_r    <= ST_HDR;
                        busy       <= 1'b1;
                        byte_data  <= hdr_byte(2'd0, frame_seq_r);
                        byte_valid <= 1'b1;
                        byte_first <= 1'b1;
                        byte_last  <= 1'b0;
                        byte_cnt_r <= {BCW{1'b0}};
                        word_cnt_r <= {WCW{1'b0}};
                    end else begin
                        busy       <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        byte_first <= 1'b0;
                        if (byte_cnt_r == BCW'(3)) begin
                            byte_valid <= 1'b0;
                            byte_cnt_r <= {BCW{1'b0}};
                            fifo_rd_en <= !fifo_empty;
                            state_r    <= ST_FETCH;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BCW'(1);
                            byte_data  <= hdr_byte(byte_cnt_r[1:0] + 2'd1, frame_seq_r);
                        end
                    end else begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                end
                ST_FETCH: begin
                    if (fifo_rd_en) begin
                        fifo_rd_en <= 1'b0;
                        state_r    <= ST_WAIT_RD;
                    end else begin
                        fifo_rd_en <= !fifo_empty;
                    end
                end
                ST_WAIT_RD: begin
                    byte_data  <= fifo_rd_data[WORD_W-1 -: 8];
                    shift_r    <= fifo_rd_data << 8;
                    byte_valid <= 1'b1;
                    byte_cnt_r <= {BCW{1'b0}};
                    byte_last  <= last_word_s && (BPW == 1);
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    if (accept_s) begin
                        if (last_byte_s) begin
                            byte_valid <= 1'b0;
                            byte_last  <= 1'b0;
                            byte_cnt_r <= {BCW{1'b0}};
                            if (last_word_s) begin
                                state_r     <= ST_IDLE;
                                busy        <= 1'b0;
                                word_cnt_r  <= {WCW{1'b0}};
                                frame_seq_r <= frame_seq_r + 16'd1;
                            end else begin
                                state_r    <= ST_FETCH;
                                word_cnt_r <= word_cnt_r + WCW'(1);
                                fifo_rd_en <= !fifo_empty;
                            end
                        end else begin
                            byte_data  <= shift_r[WORD_W-1 -: 8];
                            shift_r    <= shift_r << 8;
                            byte_cnt_r <= byte_cnt_r + BCW'(1);
                            byte_last  <= last_word_s && (byte_cnt_r == BCW'(BPW - 2));
                        end
                    end else begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    fifo_rd_en <= 1'b0;
                    byte_valid <= 1'b0;
                    byte_first <= 1'b0;
                    byte_last  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_builder.sv
// Directed bench for adc_frame_builder with WORDS_PER_FRAME=2: a queue-based FIFO model,
// a byte capture monitor and one task per scenario with hand-computed expected frames.
module tb_adc_frame_builder;

    localparam logic [47:0] W0 = 48'h123456789ABC;
    localparam logic [47:0] W1 = 48'hDEF012345678;
    localparam logic [47:0] W2 = 48'hCAFEBABE0001;
    localparam logic [47:0] W3 = 48'h0F1E2D3C4B5A;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [47:0] fifo_rd_data = 48'h0;
    logic        fifo_rd_en;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        byte_first;
    logic        byte_last;
    logic [15:0] frame_seq;
    logic        busy;

    adc_frame_builder #(
        .ADC_BITS(12), .SAMPLES(4), .WORDS_PER_FRAME(2), .HDR_MAGIC(16'hA5C3)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_first(byte_first),
        .byte_last(byte_last), .frame_seq(frame_seq), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    logic [47:0] fq[$];
    logic        fq_empty = 1'b1;
    logic        fifo_block = 1'b0;
    logic        ready_toggle = 1'b0;
    assign fifo_empty = fq_empty | fifo_block;

    int          cyc = 0;
    int          frames_done = 0;
    int          rd_err = 0;
    int          stab_err = 0;
    logic [7:0]  cap_b[$];
    logic        cap_f[$];
    logic        cap_l[$];
    int          cap_t[$];
    logic        prev_pend = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_first = 1'b0;
    logic        prev_last = 1'b0;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_b[16];

    // FIFO model, accepted-byte capture and hold-while-stalled monitor
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en === 1'b1) begin
            if (fifo_empty !== 1'b0 || fq.size() == 0) rd_err <= rd_err + 1;
            else fifo_rd_data <= fq.pop_front();
        end
        fq_empty <= (fq.size() == 0);
        if (reset_n && byte_valid === 1'b1 && byte_ready) begin
            cap_b.push_back(byte_data);
            cap_f.push_back(byte_first);
            cap_l.push_back(byte_last);
            cap_t.push_back(cyc);
            if (byte_last) frames_done <= frames_done + 1;
        end
        if (reset_n && prev_pend && (byte_valid !== 1'b1 || byte_data !== prev_data ||
                                     byte_first !== prev_first || byte_last !== prev_last))
            stab_err <= stab_err + 1;
        prev_pend  <= reset_n && (byte_valid === 1'b1) && !byte_ready;
        prev_data  <= byte_data;
        prev_first <= byte_first;
        prev_last  <= byte_last;
    end

    task automatic tick();
        @(negedge sys_clk);
        if (ready_toggle) byte_ready = ~byte_ready;
    endtask

    task automatic clear_cap();
        cap_b.delete(); cap_f.delete(); cap_l.delete(); cap_t.delete();
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (k < 400 && !ok) begin
            if (cap_b.size() >= n) ok = 1'b1;
            else begin tick(); k++; end
        end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (k < 600 && !ok) begin
            if (frames_done >= n) ok = 1'b1;
            else begin tick(); k++; end
        end
    endtask

    task automatic build_exp(input logic [15:0] seq, input logic [47:0] w0, input logic [47:0] w1);
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'hC3;
        exp_b[2] = seq[15:8];
        exp_b[3] = seq[7:0];
        for (int i = 0; i < 6; i++) begin
            exp_b[4 + i]  = w0[47 - 8*i -: 8];
            exp_b[10 + i] = w1[47 - 8*i -: 8];
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (byte_valid !== 1'b0 || byte_first !== 1'b0 || byte_last !== 1'b0 || busy !== 1'b0 ||
            fifo_rd_en !== 1'b0 || byte_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got v%b f%b l%b busy%b rd%b d%h want all 0",
                     byte_valid, byte_first, byte_last, busy, fifo_rd_en, byte_data);
        end
        total++;
        if (frame_seq !== 16'h0000) begin
            bad++; $display("FAIL reset_seq got %h want 0000", frame_seq);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        total++;
        if (busy !== 1'b0 || byte_valid !== 1'b0) begin
            bad++; $display("FAIL idle_no_enable got busy%b v%b want 0 0", busy, byte_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int fd = frames_done;
        clear_cap();
        fq.push_back(W0); fq.push_back(W1);
        enable = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_pre_start got busy=%b want 0", busy); end
        tick();
        total++;
        if (busy !== 1'b1 || byte_valid !== 1'b1 || byte_first !== 1'b1 || byte_data !== 8'hA5) begin
            bad++;
            $display("FAIL basic_start got busy%b v%b f%b d%h want 1 1 1 a5", busy, byte_valid, byte_first, byte_data);
        end
        wait_frames(fd + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout got no frame end want byte_last"); end
        build_exp(16'h0000, W0, W1);
        total++;
        if (cap_b.size() != 16) begin bad++; $display("FAIL basic_len got %0d want 16", cap_b.size()); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= cap_b.size()) begin
                bad++; $display("FAIL basic_byte%0d got missing want %h", i, exp_b[i]);
            end else if (cap_b[i] !== exp_b[i] || cap_f[i] !== (i == 0) || cap_l[i] !== (i == 15)) begin
                bad++;
                $display("FAIL basic_byte%0d got %h f%b l%b want %h f%b l%b", i, cap_b[i], cap_f[i], cap_l[i],
                         exp_b[i], (i == 0), (i == 15));
            end
        end
        total++;
        if (cap_t.size() < 11 || cap_t[1] - cap_t[0] != 1 || cap_t[4] - cap_t[3] != 3 || cap_t[10] - cap_t[9] != 3) begin
            bad++; $display("FAIL basic_spacing got gaps not 1/3/3 want 1/3/3");
        end
        tick();
        total++;
        if (frame_seq !== 16'h0001 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_end got seq %h busy%b want 0001 0", frame_seq, busy);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        bit ok;
        int fd = frames_done;
        clear_cap();
        ready_toggle = 1'b1;
        fq.push_back(W0); fq.push_back(W1);
        enable = 1'b1;
        wait_frames(fd + 1, ok);
        ready_toggle = 1'b0;
        byte_ready = 1'b1;
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout got no frame end want byte_last"); end
        build_exp(16'h0001, W0, W1);
        total++;
        if (cap_b.size() != 16) begin bad++; $display("FAIL bp_len got %0d want 16", cap_b.size()); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= cap_b.size()) begin
                bad++; $display("FAIL bp_byte%0d got missing want %h", i, exp_b[i]);
            end else if (cap_b[i] !== exp_b[i] || cap_f[i] !== (i == 0) || cap_l[i] !== (i == 15)) begin
                bad++; $display("FAIL bp_byte%0d got %h f%b l%b want %h", i, cap_b[i], cap_f[i], cap_l[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_fifo_stall();
        bit ok;
        int fd = frames_done;
        clear_cap();
        fq.push_back(W0);
        enable = 1'b1;
        wait_bytes(10, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_first_word got %0d bytes want 10", cap_b.size()); end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (byte_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
                bad++; $display("FAIL stall_cycle%0d got v%b rd%b want 0 0", i, byte_valid, fifo_rd_en);
            end
        end
        fq.push_back(W1);
        wait_frames(fd + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_timeout got no frame end want byte_last"); end
        build_exp(16'h0002, W0, W1);
        total++;
        if (cap_b.size() != 16) begin bad++; $display("FAIL stall_len got %0d want 16", cap_b.size()); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= cap_b.size()) begin
                bad++; $display("FAIL stall_byte%0d got missing want %h", i, exp_b[i]);
            end else if (cap_b[i] !== exp_b[i] || cap_l[i] !== (i == 15)) begin
                bad++; $display("FAIL stall_byte%0d got %h l%b want %h", i, cap_b[i], cap_l[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        bit ok;
        int fd = frames_done;
        tick();
        force dut.frame_seq_r = 16'hFFFF;
        tick();
        total++;
        if (frame_seq !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got %h want ffff", frame_seq); end
        clear_cap();
        fq.push_back(W2); fq.push_back(W3);
        enable = 1'b1;
        wait_bytes(4, ok);
        release dut.frame_seq_r;
        wait_frames(fd + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_timeout got no frame end want byte_last"); end
        total++;
        if (cap_b.size() < 4 || cap_b[2] !== 8'hFF || cap_b[3] !== 8'hFF) begin
            bad++; $display("FAIL wrap_hdr_ffff got size %0d want header ff ff", cap_b.size());
        end
        tick();
        total++;
        if (frame_seq !== 16'h0000) begin bad++; $display("FAIL wrap_seq got %h want 0000", frame_seq); end
        clear_cap();
        fq.push_back(W0); fq.push_back(W1);
        wait_frames(fd + 2, ok);
        build_exp(16'h0000, W0, W1);
        total++;
        if (cap_b.size() != 16) begin bad++; $display("FAIL wrap2_len got %0d want 16", cap_b.size()); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= cap_b.size()) begin
                bad++; $display("FAIL wrap2_byte%0d got missing want %h", i, exp_b[i]);
            end else if (cap_b[i] !== exp_b[i]) begin
                bad++; $display("FAIL wrap2_byte%0d got %h want %h", i, cap_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int fd;
        clear_cap();
        fq.push_back(W0); fq.push_back(W1);
        enable = 1'b1;
        wait_bytes(2, ok);
        reset_n = 1'b0;
        tick();
        total++;
        if (byte_valid !== 1'b0 || byte_first !== 1'b0 || byte_last !== 1'b0 || busy !== 1'b0 ||
            fifo_rd_en !== 1'b0 || byte_data !== 8'h00 || frame_seq !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_outputs got v%b busy%b d%h seq%h want 0 0 00 0000",
                     byte_valid, busy, byte_data, frame_seq);
        end
        clear_cap();
        fd = frames_done;
        reset_n = 1'b1;
        wait_frames(fd + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midreset_timeout got no frame end want byte_last"); end
        build_exp(16'h0000, W0, W1);
        total++;
        if (cap_b.size() != 16) begin bad++; $display("FAIL midreset_len got %0d want 16", cap_b.size()); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= cap_b.size()) begin
                bad++; $display("FAIL midreset_byte%0d got missing want %h", i, exp_b[i]);
            end else if (cap_b[i] !== exp_b[i] || cap_f[i] !== (i == 0)) begin
                bad++; $display("FAIL midreset_byte%0d got %h f%b want %h", i, cap_b[i], cap_f[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int fd = frames_done;
        clear_cap();
        fq.push_back(W2); fq.push_back(W3); fq.push_back(W0); fq.push_back(W1);
        enable = 1'b1;
        wait_bytes(5, ok);
        enable = 1'b0;
        wait_frames(fd + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL endrop_timeout got no frame end want byte_last"); end
        build_exp(16'h0001, W2, W3);
        total++;
        if (cap_b.size() != 16) begin bad++; $display("FAIL endrop_len got %0d want 16", cap_b.size()); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= cap_b.size()) begin
                bad++; $display("FAIL endrop_byte%0d got missing want %h", i, exp_b[i]);
            end else if (cap_b[i] !== exp_b[i] || cap_l[i] !== (i == 15)) begin
                bad++; $display("FAIL endrop_byte%0d got %h l%b want %h", i, cap_b[i], cap_l[i], exp_b[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (busy !== 1'b0 || byte_valid !== 1'b0) begin
                bad++; $display("FAIL endrop_idle%0d got busy%b v%b want 0 0", i, busy, byte_valid);
            end
        end
        total++;
        if (fq.size() != 2 || frame_seq !== 16'h0002) begin
            bad++; $display("FAIL endrop_left got fifo %0d seq %h want 2 0002", fq.size(), frame_seq);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back_backpressure();
        test_fifo_stall();
        test_seq_wrap();
        test_reset_mid_frame();
        test_enable_drop();
        total++;
        if (rd_err != 0) begin bad++; $display("FAIL fifo_read_rule got %0d bad strobes want 0", rd_err); end
        total++;
        if (stab_err != 0) begin bad++; $display("FAIL hold_stable got %0d changes want 0", stab_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
